// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / data memory) arbiter in front of
//               a shared single-port memory. At most one transaction is
//               outstanding. A memory that never acknowledges is aborted after
//               TIMEOUT_CYC cycles with a one-cycle err_o pulse.
//               Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
//               requests; otherwise the data port always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction fetch requester (read-only)
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  // data memory requester
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  // shared backing memory
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  // status
  output logic        stall_o,
  output logic        err_o
);

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT_CYC[7:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_dm_q, gnt_dm_d;     // 1: data port owns the transaction
  logic        mem_enable_q, mem_enable_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        err_q, err_d;
  logic        pick_dm;                 // grant decision for this IDLE cycle
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_dm_q, last_dm_d;    // 1: data port was granted last
`endif

  // Choose which requester would be granted if the arbiter is idle
  always_comb begin
    pick_dm = dm_req_i;
`ifdef ARB_ROUND_ROBIN_EN
    if (if_req_i && dm_req_i) begin
      pick_dm = ~last_dm_q;
    end
`endif
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_dm_d     = gnt_dm_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    err_d        = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_dm_d    = last_dm_q;
`endif

    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d      = BUSY;
          cnt_d        = 8'd0;
          gnt_dm_d     = pick_dm;
          mem_enable_d = 1'b1;
          // Fetches never write and carry no write data
          mem_write_d  = pick_dm & dm_we_i;
          mem_addr_d   = pick_dm ? dm_addr_i  : if_addr_i;
          mem_wdata_d  = pick_dm ? dm_wdata_i : 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
          last_dm_d    = pick_dm;
`endif
        end
      end

      BUSY: begin
        // An acknowledge arriving on the timeout cycle still completes normally
        if (mem_ack_i) begin
          state_d      = RESP;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          if_ack_d     = ~gnt_dm_q;
          dm_ack_d     = gnt_dm_q;
          if (!gnt_dm_q) begin
            if_rdata_d = mem_rdata_i;
          end else if (!mem_write_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d      = RESP;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          if_ack_d     = ~gnt_dm_q;
          dm_ack_d     = gnt_dm_q;
          err_d        = 1'b1;
          if (!gnt_dm_q) begin
            if_rdata_d = 32'h0;
          end else if (!mem_write_q) begin
            dm_rdata_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        // Single response cycle; requests seen here are deliberately ignored
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      gnt_dm_q     <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      if_rdata_q   <= 32'h0;
      dm_rdata_q   <= 32'h0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      err_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_dm_q     <= gnt_dm_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      err_q        <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dm_q    <= last_dm_d;
`endif
    end
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign if_rdata_o   = if_rdata_q;
  assign dm_rdata_o   = dm_rdata_q;
  assign if_ack_o     = if_ack_q;
  assign dm_ack_o     = dm_ack_q;
  assign err_o        = err_q;

  // A requester stalls the pipeline until its acknowledge is visible
  assign stall_o = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
`default_nettype wire
